// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared word type, drop counter width and signature step for rng_fifo
package rng_pkg;

  typedef logic [31:0] rng_word_t;

  localparam int DROP_CNT_W = 16;

  // Rotate-left-by-one then fold in the popped word.
  function automatic rng_word_t sig_next(rng_word_t sig, rng_word_t word);
    return {sig[30:0], sig[31]} ^ word;
  endfunction

endpackage

// File: rtl/rng_decim.sv
// rtl/rng_decim.sv - decimation counter; strobes once every DECIM enabled cycles
module rng_decim #(
  parameter int DECIM = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic strobe_o
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  logic [CW-1:0] cnt;

  assign strobe_o = en_i && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rng_fifo.sv
// rtl/rng_fifo.sv - decimated LFSR sampler feeding a FWFT FIFO with drop counter
// Optional popped-word signature on sig_o enabled by macro RNG_FIFO_SIG_EN.
module rng_fifo
  import rng_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DECIM = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic [31:0]             lfsr_state_i,
  output logic [31:0]             rnd_o,
  output logic                    rnd_valid_o,
  input  logic                    rnd_ready_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [DROP_CNT_W-1:0]   drop_cnt_o,
  output logic [31:0]             sig_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rng_word_t     mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          strobe;
  logic          full;
  logic          push;
  logic          pop;

  rng_decim #(.DECIM(DECIM)) u_decim (
    .clk      (clk),
    .reset    (reset),
    .en_i     (en_i),
    .strobe_o (strobe)
  );

  assign rnd_valid_o = (count_o != '0);
  assign full        = (count_o == CW'(DEPTH));
  assign pop         = rnd_valid_o && rnd_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push        = strobe && (!full || pop);
  assign rnd_o       = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= lfsr_state_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count_o    <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count_o <= count_o + CW'(1);
      else if (pop && !push) count_o <= count_o - CW'(1);
      if (strobe && full && !pop && (drop_cnt_o != '1)) begin
        drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
      end
    end
  end

`ifdef RNG_FIFO_SIG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_o <= '0;
    end else if (pop) begin
      sig_o <= sig_next(sig_o, rnd_o);
    end
  end
`else
  assign sig_o = '0;
`endif

endmodule

// File: tb/tb_rng_fifo.sv
// tb/tb_rng_fifo.sv - directed self-checking bench for rng_fifo (DEPTH=8, DECIM=4)
module tb_rng_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_i = 1'b0;
  logic [31:0] lfsr_state_i;
  logic [31:0] rnd_o;
  logic        rnd_valid_o;
  logic        rnd_ready_i = 1'b0;
  logic [3:0]  count_o;
  logic [15:0] drop_cnt_o;
  logic [31:0] sig_o;

  int k = 0;
  int checks = 0;
  int errors = 0;

  assign lfsr_state_i = 32'(k);

  always #5 clk = ~clk;

  rng_fifo #(.DEPTH(8), .DECIM(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .en_i         (en_i),
    .lfsr_state_i (lfsr_state_i),
    .rnd_o        (rnd_o),
    .rnd_valid_o  (rnd_valid_o),
    .rnd_ready_i  (rnd_ready_i),
    .count_o      (count_o),
    .drop_cnt_o   (drop_cnt_o),
    .sig_o        (sig_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en_i = 1'b0;
    rnd_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    k = 0;
  endtask

  task automatic run_to(input int target);
    for (int n = 0; n < 200 && k < target; n++) step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    checks++; if (rnd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rnd_valid_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
    checks++; if (sig_o !== 32'd0) begin errors++; $display("FAIL reset_sig got %0d want 0", sig_o); end
  endtask

  // Expects to be entered right after reset release (k=0).
  task automatic test_stream(input string tag);
    en_i = 1'b1;
    rnd_ready_i = 1'b1;
    for (int n = 0; n < 16; n++) begin
      checks++;
      if (count_o > 4'd1) begin errors++; $display("FAIL %s_count_le1 k=%0d got %0d want <=1", tag, k, count_o); end
      if (k == 3) begin
        checks++; if (rnd_valid_o !== 1'b0) begin errors++; $display("FAIL %s_valid_k3 got %b want 0", tag, rnd_valid_o); end
      end
      if (k == 4) begin
        checks++; if (rnd_valid_o !== 1'b1 || rnd_o !== 32'd3) begin errors++; $display("FAIL %s_word_k4 got v=%b %0d want v=1 3", tag, rnd_valid_o, rnd_o); end
      end
      if (k == 8) begin
        checks++; if (rnd_valid_o !== 1'b1 || rnd_o !== 32'd7) begin errors++; $display("FAIL %s_word_k8 got v=%b %0d want v=1 7", tag, rnd_valid_o, rnd_o); end
      end
      if (k == 12) begin
        checks++; if (rnd_valid_o !== 1'b1 || rnd_o !== 32'd11) begin errors++; $display("FAIL %s_word_k12 got v=%b %0d want v=1 11", tag, rnd_valid_o, rnd_o); end
      end
`ifdef RNG_FIFO_SIG_EN
      if (k == 5) begin
        checks++; if (sig_o !== 32'd3) begin errors++; $display("FAIL %s_sig_k5 got %0d want 3", tag, sig_o); end
      end
      if (k == 9) begin
        checks++; if (sig_o !== 32'd1) begin errors++; $display("FAIL %s_sig_k9 got %0d want 1", tag, sig_o); end
      end
`else
      checks++;
      if (sig_o !== 32'd0) begin errors++; $display("FAIL %s_sig_zero k=%0d got %0d want 0", tag, k, sig_o); end
`endif
      step();
    end
  endtask

  task automatic test_fill_drop();
    do_reset();
    en_i = 1'b1;
    rnd_ready_i = 1'b0;
    run_to(31);
    checks++; if (count_o !== 4'd7) begin errors++; $display("FAIL fill_count_k31 got %0d want 7", count_o); end
    run_to(32);
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL fill_count_k32 got %0d want 8", count_o); end
    run_to(36);
    checks++; if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL drop_k36 got %0d want 1", drop_cnt_o); end
    run_to(40);
    checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL drop_k40 got %0d want 2", drop_cnt_o); end
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL fill_count_k40 got %0d want 8", count_o); end
    checks++; if (rnd_o !== 32'd3) begin errors++; $display("FAIL fill_head_k40 got %0d want 3", rnd_o); end
  endtask

  // Continues from the full FIFO left by test_fill_drop.
  task automatic test_full_pop();
    logic [31:0] exp_words [8];
    exp_words = '{32'd7, 32'd11, 32'd15, 32'd19, 32'd23, 32'd27, 32'd31, 32'd43};
    run_to(43);
    rnd_ready_i = 1'b1;
    step();
    rnd_ready_i = 1'b0;
    en_i = 1'b0;
    checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL fullpop_drop got %0d want 2", drop_cnt_o); end
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL fullpop_count got %0d want 8", count_o); end
    checks++; if (rnd_o !== 32'd7) begin errors++; $display("FAIL fullpop_head got %0d want 7", rnd_o); end
    rnd_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rnd_valid_o !== 1'b1 || rnd_o !== exp_words[i]) begin
        errors++; $display("FAIL drain_%0d got v=%b %0d want v=1 %0d", i, rnd_valid_o, rnd_o, exp_words[i]);
      end
      step();
    end
    checks++; if (rnd_valid_o !== 1'b0 || count_o !== 4'd0) begin errors++; $display("FAIL drained got v=%b c=%0d want v=0 c=0", rnd_valid_o, count_o); end
    repeat (3) step();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL no_underflow got %0d want 0", count_o); end
    rnd_ready_i = 1'b0;
  endtask

  task automatic test_en_gap();
    do_reset();
    rnd_ready_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      en_i = (k >= 1 && k <= 5) ? 1'b0 : 1'b1;
      if (k == 8) begin
        checks++; if (rnd_valid_o !== 1'b0) begin errors++; $display("FAIL gap_valid_k8 got %b want 0", rnd_valid_o); end
      end
      if (k == 9) begin
        checks++; if (rnd_valid_o !== 1'b1 || rnd_o !== 32'd8) begin errors++; $display("FAIL gap_word_k9 got v=%b %0d want v=1 8", rnd_valid_o, rnd_o); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en_i = 1'b1;
    rnd_ready_i = 1'b0;
    run_to(20);
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL mid_pre_count got %0d want 5", count_o); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL mid_count got %0d want 0", count_o); end
    checks++; if (rnd_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", rnd_valid_o); end
    checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL mid_drop got %0d want 0", drop_cnt_o); end
    do_reset();
    test_stream("after_reset");
  endtask

  initial begin
    test_reset();
    test_stream("stream");
    test_fill_drop();
    test_full_pop();
    test_en_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
